// File: rtl/packetizer_rr_arbiter.sv
// Round-robin arbiter sharing one packetizer input port among NUM_REQ requesters.
// Grants are held for bursts of up to MAX_BURST words; the output stage is a single registered slot.
module packetizer_rr_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned WIDTH_IN      = 12,
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned MAX_BURST     = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ*WIDTH_IN-1:0]      req_data_in,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_dst_in,
    input  logic [NUM_REQ-1:0]               req_valid_in,
    input  logic [NUM_REQ-1:0]               req_last_in,
    output logic [NUM_REQ-1:0]               req_ready_out,
    output logic [WIDTH_IN-1:0]              data_out,
    output logic [ADDRESS_WIDTH-1:0]         dst_out,
    output logic                             valid_out,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id_out,
    input  logic                             ready_in
);

    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW  = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                   state, state_nxt;
    logic [IDW-1:0]           ptr, ptr_nxt;
    logic [IDW-1:0]           lock_id, lock_nxt;
    logic [CW-1:0]            cnt, cnt_nxt;

    logic                     load_en;
    logic                     have_grant;
    logic [IDW-1:0]           sel;
    logic                     sel_valid;
    logic                     sel_last;
    logic [WIDTH_IN-1:0]      sel_data;
    logic [ADDRESS_WIDTH-1:0] sel_dst;
    logic                     accept;
    logic                     burst_end;

    // Grant selection: locked requester, else first valid scanning from ptr.
    always_comb begin
        have_grant = 1'b0;
        sel        = lock_id;
        if (state == LOCKED) begin
            have_grant = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                for (int unsigned j = 0; j < NUM_REQ; j++) begin
                    if (!have_grant && req_valid_in[j] &&
                        (j == (32'(ptr) + k) % NUM_REQ)) begin
                        have_grant = 1'b1;
                        sel        = IDW'(j);
                    end
                end
            end
        end
    end

    // Selected requester's fields and per-requester ready.
    always_comb begin
        load_en       = !valid_out || ready_in;
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        sel_data      = '0;
        sel_dst       = '0;
        req_ready_out = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (IDW'(j) == sel) begin
                sel_valid        = req_valid_in[j];
                sel_last         = req_last_in[j];
                sel_data         = req_data_in[j*WIDTH_IN +: WIDTH_IN];
                sel_dst          = req_dst_in[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                req_ready_out[j] = rst_n && load_en && have_grant &&
                                   ((state == LOCKED) || req_valid_in[j]);
            end
        end
        accept    = have_grant && load_en && sel_valid;
        burst_end = sel_last || ((32'(cnt) + 32'd1) >= MAX_BURST);
    end

    // Next-state: lock on non-final words, release and advance ptr when a burst ends.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        lock_nxt  = lock_id;
        cnt_nxt   = cnt;
        if (accept) begin
            if (burst_end) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                ptr_nxt   = (32'(sel) == NUM_REQ - 1) ? '0 : sel + IDW'(1);
            end else begin
                state_nxt = LOCKED;
                lock_nxt  = sel;
                cnt_nxt   = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            lock_id <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            lock_id <= lock_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // Output slot: load on accept, empty on an idle load cycle, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out    <= 1'b0;
            data_out     <= '0;
            dst_out      <= '0;
            grant_id_out <= '0;
        end else if (load_en) begin
            valid_out <= accept;
            if (accept) begin
                data_out     <= sel_data;
                dst_out      <= sel_dst;
                grant_id_out <= sel;
            end
        end
    end

endmodule

// File: tb/tb_packetizer_rr_arbiter.sv
// Directed self-checking bench for packetizer_rr_arbiter (4 requesters, 12-bit payload, burst cap 4).
module tb_packetizer_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 12;
    localparam int unsigned AW = 4;
    localparam int unsigned MB = 4;

    logic              clk;
    logic              rst_n;
    logic [N*W-1:0]    req_data_in;
    logic [N*AW-1:0]   req_dst_in;
    logic [N-1:0]      req_valid_in;
    logic [N-1:0]      req_last_in;
    logic [N-1:0]      req_ready_out;
    logic [W-1:0]      data_out;
    logic [AW-1:0]     dst_out;
    logic              valid_out;
    logic [1:0]        grant_id_out;
    logic              ready_in;

    int n_checks;
    int n_fail;
    int grants [N];

    packetizer_rr_arbiter #(
        .NUM_REQ(N), .WIDTH_IN(W), .ADDRESS_WIDTH(AW), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_data_in(req_data_in), .req_dst_in(req_dst_in),
        .req_valid_in(req_valid_in), .req_last_in(req_last_in),
        .req_ready_out(req_ready_out),
        .data_out(data_out), .dst_out(dst_out), .valid_out(valid_out),
        .grant_id_out(grant_id_out), .ready_in(ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] d, input logic [AW-1:0] a,
                           input logic l, input logic v);
        req_data_in[i*W +: W]   = d;
        req_dst_in[i*AW +: AW]  = a;
        req_last_in[i]          = l;
        req_valid_in[i]         = v;
    endtask

    task automatic clear_all();
        req_valid_in = '0;
        req_last_in  = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < N; i++) grants[i] = 0;
        rst_n        = 1'b0;
        ready_in     = 1'b1;
        req_data_in  = '0;
        req_dst_in   = '0;
        clear_all();

        // Reset state, with a requester already valid.
        set_req(2, 12'h2A0, 4'd5, 1'b0, 1'b1);
        tick();
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_dst", 32'(dst_out), 32'd0);
        check("rst_gid", 32'(grant_id_out), 32'd0);
        check("rst_ready", 32'(req_ready_out), 32'd0);
        rst_n = 1'b1;

        // Single requester 2: three words, last on the third.
        #1;
        check("s_ready0", 32'(req_ready_out), 32'b0100);
        tick();
        check("s_valid0", 32'(valid_out), 32'd1);
        check("s_data0", 32'(data_out), 32'h2A0);
        check("s_dst0", 32'(dst_out), 32'd5);
        check("s_gid0", 32'(grant_id_out), 32'd2);
        set_req(2, 12'h2A1, 4'd5, 1'b0, 1'b1);
        #1;
        check("s_ready1", 32'(req_ready_out), 32'b0100);
        tick();
        check("s_data1", 32'(data_out), 32'h2A1);
        set_req(2, 12'h2A2, 4'd5, 1'b1, 1'b1);
        tick();
        check("s_data2", 32'(data_out), 32'h2A2);
        check("s_gid2", 32'(grant_id_out), 32'd2);
        clear_all();
        tick();
        check("s_drain_valid", 32'(valid_out), 32'd0);
        check("s_drain_data", 32'(data_out), 32'h2A2);

        // ptr is now 3: with everyone valid, requester 3 wins first.
        for (int i = 0; i < N; i++) set_req(i, 12'hA00 | 12'(i), 4'(i + 8), 1'b1, 1'b1);
        #1;
        check("ptr3_ready", 32'(req_ready_out), 32'b1000);
        tick();
        check("ptr3_gid", 32'(grant_id_out), 32'd3);

        // Round robin over 40 single-word bursts.
        for (int c = 0; c < 40; c++) begin
            #1;
            check("rr_ready", 32'(req_ready_out), 32'd1 << (c % 4));
            tick();
            check("rr_gid", 32'(grant_id_out), 32'(c % 4));
            check("rr_data", 32'(data_out), 32'hA00 | 32'(c % 4));
            grants[grant_id_out]++;
        end
        for (int i = 0; i < N; i++) check("rr_share", 32'(grants[i]), 32'd10);
        clear_all();
        tick();

        // Burst cap: 1 and 3 stream with last=0, ptr=0.
        set_req(1, 12'h101, 4'd1, 1'b0, 1'b1);
        set_req(3, 12'h303, 4'd3, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("cap_gid", 32'(grant_id_out), (c < 4 || c >= 8) ? 32'd1 : 32'd3);
            check("cap_valid", 32'(valid_out), 32'd1);
        end
        clear_all();
        set_req(1, 12'h1FF, 4'd1, 1'b1, 1'b1);
        tick();
        check("cap_close", 32'(data_out), 32'h1FF);
        clear_all();
        tick();

        // Backpressure: word from requester 0 held for 5 stalled cycles (ptr=2).
        set_req(0, 12'h5A5, 4'd9, 1'b1, 1'b1);
        #1;
        check("bp_ready0", 32'(req_ready_out), 32'b0001);
        tick();
        check("bp_data0", 32'(data_out), 32'h5A5);
        clear_all();
        set_req(1, 12'h3C3, 4'd7, 1'b1, 1'b1);
        ready_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_ready_stall", 32'(req_ready_out), 32'd0);
            tick();
            check("bp_data_hold", 32'(data_out), 32'h5A5);
            check("bp_dst_hold", 32'(dst_out), 32'd9);
            check("bp_valid_hold", 32'(valid_out), 32'd1);
        end
        ready_in = 1'b1;
        #1;
        check("bp_ready_resume", 32'(req_ready_out), 32'b0010);
        tick();
        check("bp_data_next", 32'(data_out), 32'h3C3);
        check("bp_gid_next", 32'(grant_id_out), 32'd1);
        clear_all();
        tick();
        check("bp_no_dup", 32'(valid_out), 32'd0);

        // Locked bubble: requester 0 locked, drops valid; requester 1 waits (ptr=2).
        set_req(0, 12'h111, 4'd2, 1'b0, 1'b1);
        set_req(1, 12'h222, 4'd4, 1'b1, 1'b1);
        tick();
        check("lb_gid0", 32'(grant_id_out), 32'd0);
        req_valid_in[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("lb_ready_lock", 32'(req_ready_out), 32'b0001);
            tick();
            check("lb_bubble", 32'(valid_out), 32'd0);
        end
        set_req(0, 12'h113, 4'd2, 1'b1, 1'b1);
        tick();
        check("lb_resume_data", 32'(data_out), 32'h113);
        check("lb_resume_gid", 32'(grant_id_out), 32'd0);
        req_valid_in[0] = 1'b0;
        #1;
        check("lb_ready1", 32'(req_ready_out), 32'b0010);
        tick();
        check("lb_gid1", 32'(grant_id_out), 32'd1);
        check("lb_data1", 32'(data_out), 32'h222);
        clear_all();
        tick();

        // Reset in the middle of a locked burst from requester 3 (ptr=2).
        set_req(3, 12'h333, 4'd3, 1'b0, 1'b1);
        tick();
        tick();
        check("mr_pre_valid", 32'(valid_out), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(valid_out), 32'd0);
        check("mr_data", 32'(data_out), 32'd0);
        check("mr_dst", 32'(dst_out), 32'd0);
        check("mr_gid", 32'(grant_id_out), 32'd0);
        check("mr_ready", 32'(req_ready_out), 32'd0);
        tick();
        rst_n = 1'b1;
        set_req(1, 12'h121, 4'd1, 1'b1, 1'b1);
        set_req(3, 12'h323, 4'd3, 1'b1, 1'b1);
        #1;
        check("mr_restart_ready", 32'(req_ready_out), 32'b0010);
        tick();
        check("mr_restart_gid", 32'(grant_id_out), 32'd1);
        tick();
        check("mr_next_gid", 32'(grant_id_out), 32'd3);
        check("mr_next_data", 32'(data_out), 32'h323);
        clear_all();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
